// File: rtl/qdr_wb_ctrl_pkg.sv
// qdr_wb_ctrl shared definitions: register map, channel
// states and STATUS/CTRL bit positions.
package qdr_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_READY = 2'd1,
    ST_FAIL  = 2'd2,
    ST_RESET = 2'd3
  } ch_state_e;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_FREQ   = 3'd2;
  localparam logic [2:0] REG_RSTCNT = 3'd3;
  localparam logic [2:0] REG_TOCFG  = 3'd4;

  localparam int STS_PHY  = 0;
  localparam int STS_CAL  = 4;
  localparam int STS_ST   = 8;
  localparam int STS_TO   = 12;
  localparam int STS_LOST = 13;
  localparam int STS_EXH  = 14;

  localparam int CTRL_RST = 0;
  localparam int CTRL_CLR = 1;

  function automatic logic [15:0] mk_status(
    input logic      phy,
    input logic      cal,
    input ch_state_e st,
    input logic      to,
    input logic      lost,
    input logic      exh
  );
    logic [15:0] s;
    s = '0;
    s[STS_PHY]     = phy;
    s[STS_CAL]     = cal;
    s[STS_ST +: 2] = st;
    s[STS_TO]      = to;
    s[STS_LOST]    = lost;
    s[STS_EXH]     = exh;
    return s;
  endfunction

endpackage

// File: rtl/qdr_wb_ch_fsm.sv
// Per-channel QDR supervisor: input synchroniser, reset
// stretcher, calibration timeout, auto-retry and stickies.
module qdr_wb_ch_fsm
  import qdr_wb_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 32,
  parameter int TO_SHIFT   = 8,
  parameter int AUTO_RETRY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_phy_ready,
  input  logic        i_cal_fail,
  input  logic        i_sw_rst,
  input  logic        i_clr,
  input  logic [15:0] i_to_cfg,
  output logic        o_qdr_reset,
  output logic [15:0] o_status,
  output logic [15:0] o_rst_count
);

  localparam int TW = 16 + TO_SHIFT;
  localparam int CW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(RST_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(AUTO_RETRY);

  logic [1:0]    r_rdy_sync;
  logic [1:0]    r_fail_sync;
  ch_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_retry;
  logic          r_st_to;
  logic          r_st_lost;
  logic          r_st_exh;
  logic [15:0]   r_rst_cnt;
  logic          r_qrst;

  logic          w_rdy;
  logic          w_fail;
  logic [TW:0]   w_tinc;
  logic [TW:0]   w_limit;
  ch_state_e     w_nstate;
  logic [CW-1:0] w_cnt_nx;
  logic [TW-1:0] w_timer_nx;
  logic [3:0]    w_retry_nx;
  logic          w_set_to;
  logic          w_set_lost;
  logic          w_set_exh;
  logic          w_enter;

  assign w_rdy   = r_rdy_sync[1];
  assign w_fail  = r_fail_sync[1];
  assign w_tinc  = {1'b0, r_timer} + (TW+1)'(1);
  assign w_limit = (TW+1)'(i_to_cfg) << TO_SHIFT;

  always_comb begin
    w_nstate   = r_state;
    w_cnt_nx   = r_cnt;
    w_timer_nx = r_timer;
    w_retry_nx = r_retry;
    w_set_to   = 1'b0;
    w_set_lost = 1'b0;
    w_set_exh  = 1'b0;
    w_enter    = 1'b0;
    if (i_sw_rst) begin
      w_nstate   = ST_RESET;
      w_cnt_nx   = CNT_LOAD;
      w_retry_nx = '0;
      w_enter    = 1'b1;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (r_cnt == '0) begin
            w_nstate   = ST_WAIT;
            w_timer_nx = '0;
          end else begin
            w_cnt_nx = r_cnt - CW'(1);
          end
        end
        ST_WAIT: begin
          if (w_rdy) begin
            w_nstate = ST_READY;
          end else if (w_fail) begin
            w_nstate = ST_FAIL;
          end else if (i_to_cfg != '0 &&
                       w_tinc >= w_limit) begin
            w_nstate = ST_FAIL;
            w_set_to = 1'b1;
          end else if (r_timer != '1) begin
            w_timer_nx = w_tinc[TW-1:0];
          end
        end
        ST_READY: begin
          if (!w_rdy) begin
            w_nstate   = ST_WAIT;
            w_set_lost = 1'b1;
            w_timer_nx = '0;
          end
        end
        ST_FAIL: begin
          if (r_retry < RETRY_MAX) begin
            w_nstate   = ST_RESET;
            w_cnt_nx   = CNT_LOAD;
            w_retry_nx = r_retry + 4'd1;
            w_enter    = 1'b1;
          end else begin
            w_set_exh = 1'b1;
          end
        end
        default: w_nstate = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdy_sync  <= '0;
      r_fail_sync <= '0;
      r_state     <= ST_WAIT;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_retry     <= '0;
      r_st_to     <= 1'b0;
      r_st_lost   <= 1'b0;
      r_st_exh    <= 1'b0;
      r_rst_cnt   <= '0;
      r_qrst      <= 1'b0;
    end else begin
      r_rdy_sync  <= {r_rdy_sync[0], i_phy_ready};
      r_fail_sync <= {r_fail_sync[0], i_cal_fail};
      r_state     <= w_nstate;
      r_cnt       <= w_cnt_nx;
      r_timer     <= w_timer_nx;
      r_retry     <= w_retry_nx;
      r_qrst      <= (w_nstate == ST_RESET);
      // a set in the same cycle as a clear must survive
      r_st_to     <= w_set_to | (r_st_to & ~i_clr);
      r_st_lost   <= w_set_lost | (r_st_lost & ~i_clr);
      r_st_exh    <= w_set_exh | (r_st_exh & ~i_clr);
      if (w_enter && r_rst_cnt != 16'hFFFF)
        r_rst_cnt <= r_rst_cnt + 16'd1;
    end
  end

  assign o_qdr_reset = r_qrst;
  assign o_rst_count = r_rst_cnt;
  assign o_status    = mk_status(w_rdy, w_fail, r_state,
                                 r_st_to, r_st_lost,
                                 r_st_exh);

endmodule

// File: rtl/qdr_wb_ctrl.sv
// Multi-channel QDR control/status Wishbone slave: bus
// decode, TIMEOUT_CFG registers and read mux.
module qdr_wb_ctrl
  import qdr_wb_ctrl_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          CLK_FREQ   = 0,
  parameter int          RST_CYCLES = 32,
  parameter int          TO_SHIFT   = 8,
  parameter logic [15:0] TO_DEFAULT = 16'd1024,
  parameter int          AUTO_RETRY = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  output logic              wb_ack_o,
  input  logic [NUM_CH-1:0] phy_ready,
  input  logic [NUM_CH-1:0] cal_fail,
  output logic [NUM_CH-1:0] qdr_reset
);

  localparam logic [15:0] FREQ_VAL = 16'(CLK_FREQ);

  logic              r_ack;
  logic [15:0]       r_dat;
  logic [15:0]       r_to_cfg [NUM_CH];

  logic [2:0]        w_ch;
  logic [2:0]        w_reg;
  logic              w_acc;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic [15:0]       w_rdata;
  logic [15:0]       w_status [NUM_CH];
  logic [15:0]       w_rst_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_sw_rst;
  logic [NUM_CH-1:0] w_clr;
  logic              w_unused;

  assign w_ch      = wb_adr_i[6:4];
  assign w_reg     = wb_adr_i[3:1];
  assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_wr_ctrl = w_wr & wb_sel_i[0] &
                     (w_reg == REG_CTRL);
  assign w_unused  = ^{wb_adr_i[31:7], wb_adr_i[0]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_sw_rst[g] = w_wr_ctrl &
                         (w_ch == 3'(g)) &
                         wb_dat_i[CTRL_RST];
    assign w_clr[g]    = w_wr_ctrl &
                         (w_ch == 3'(g)) &
                         wb_dat_i[CTRL_CLR];

    qdr_wb_ch_fsm #(
      .RST_CYCLES (RST_CYCLES),
      .TO_SHIFT   (TO_SHIFT),
      .AUTO_RETRY (AUTO_RETRY)
    ) u_ch (
      .i_clk       (wb_clk_i),
      .i_rst_n     (wb_rst_n_i),
      .i_phy_ready (phy_ready[g]),
      .i_cal_fail  (cal_fail[g]),
      .i_sw_rst    (w_sw_rst[g]),
      .i_clr       (w_clr[g]),
      .i_to_cfg    (r_to_cfg[g]),
      .o_qdr_reset (qdr_reset[g]),
      .o_status    (w_status[g]),
      .o_rst_count (w_rst_cnt[g])
    );
  end

  // out-of-range channels match no entry, so they read 0
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 3'(i)) begin
        unique case (w_reg)
          REG_STATUS: w_rdata = w_status[i];
          REG_FREQ:   w_rdata = FREQ_VAL;
          REG_RSTCNT: w_rdata = w_rst_cnt[i];
          REG_TOCFG:  w_rdata = r_to_cfg[i];
          default:    w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < NUM_CH; i++)
        r_to_cfg[i] <= TO_DEFAULT;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr && w_ch == 3'(i) &&
            w_reg == REG_TOCFG) begin
          if (wb_sel_i[0])
            r_to_cfg[i][7:0] <= wb_dat_i[7:0];
          if (wb_sel_i[1])
            r_to_cfg[i][15:8] <= wb_dat_i[15:8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_acc)
        r_dat <= w_rdata;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;

endmodule

// File: doc/qdr_wb_ctrl.md
Name: qdr_wb_ctrl

Overview:
Parametrised multi-channel Wishbone control/status slave for up to 8 QDR controllers, the successor to the single-channel QDR register attach. Each channel gets a supervisor FSM. The FSM stretches CPU reset requests to a programmable pulse width, times out calibration, and auto-retries failed calibration. It also keeps sticky fault flags and a reset counter. The block sits on the 16-bit CPU Wishbone bus beside the QDR PHYs.

Parameters:
NUM_CH, 2, number of QDR channels (1..8)
CLK_FREQ, 0, clock frequency in MHz, returned by the FREQ register
RST_CYCLES, 32, width of the qdr_reset pulse in wb_clk_i cycles (>=1)
TO_SHIFT, 8, timeout unit is 2^TO_SHIFT cycles
TO_DEFAULT, 16'd1024, reset value of TIMEOUT_CFG (0 disables timeout)
AUTO_RETRY, 2, automatic re-resets allowed after FAIL per software request (0..15)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_n_i  in  1  asynchronous active-low reset
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_sel_i  in  2  byte selects
wb_adr_i  in  32  byte address
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_ack_o  out  1  acknowledge
phy_ready  in  NUM_CH  per-channel PHY ready (asynchronous, QDR domain)
cal_fail  in  NUM_CH  per-channel calibration fail (asynchronous)
qdr_reset  out  NUM_CH  per-channel reset to the QDR controller

Behaviour:
- Reset: one clock, wb_clk_i. wb_rst_n_i is asynchronous and active-low. While wb_rst_n_i is low: wb_ack_o=0, wb_dat_o=0, qdr_reset=0, every channel in WAIT, counters 0, stickies 0, TIMEOUT_CFG=TO_DEFAULT.
- Input synchronisation: phy_ready and cal_fail each pass through a 2-flop synchroniser. The FSM uses only the synchronised values. Latency is 2 cycles.
- Decode: channel = wb_adr_i[6:4]; reg = wb_adr_i[3:1]. A channel index >= NUM_CH reads 0 and ignores writes.
- Registers:
  0 STATUS, RO: [0]=phy_ready, [4]=cal_fail, [9:8]=state, [12]=timeout sticky, [13]=lost-lock sticky, [14]=retry-exhausted sticky.
  1 CTRL, WO, reads 0: [0]=1 requests reset; [1]=1 clears all stickies. Both bits are in byte 0 and need wb_sel_i[0].
  2 FREQ, RO: CLK_FREQ[15:0].
  3 RST_COUNT, RO: resets issued, 16 bits, saturating at 16'hFFFF.
  4 TIMEOUT_CFG, RW: byte-lane writes per wb_sel_i.
  5-7: read 0.
- Handshake:
  - wb_ack_o is asserted the cycle after cyc&stb&~ack and lasts exactly one cycle.
  - wb_dat_o is registered and valid with ack, held until the next access.
  - A write takes effect on the ack edge.
- FSM per channel. States: WAIT=0, READY=1, FAIL=2, RESET=3.
  - RESET: qdr_reset=1; cnt counts RST_CYCLES-1 down to 0. At 0 → WAIT with the timeout counter cleared.
  - WAIT: phy_ready → READY. Else cal_fail → FAIL. Else if TIMEOUT_CFG≠0 and the timer reaches TIMEOUT_CFG<<TO_SHIFT → FAIL and set the timeout sticky.
  - READY: phy_ready low → WAIT, set the lost-lock sticky, clear the timer.
  - FAIL:
    - If the retry count < AUTO_RETRY: → RESET next cycle, increment the retry count.
    - Else: stay in FAIL and set the retry-exhausted sticky.
- A software reset request forces RESET from any state. It clears the retry count. RST_COUNT increments on every entry to RESET, software or automatic.
- A request while already in RESET reloads the pulse counter, so the pulse is extended, and RST_COUNT increments.
- Simultaneous sticky clear and sticky set in one cycle: set wins.
- The timer is frozen outside WAIT and does not wrap. Its width is 16+TO_SHIFT bits.
- qdr_reset is driven straight from a register, so it is glitch-free.

Decomposition:
- Shared header/package: register offsets, state encodings, STATUS bit positions, CTRL bit positions.
- Sub-module qdr_wb_ch_fsm, one instance per channel, generated. It holds the synchroniser, FSM, timer, retry count, stickies and RST_COUNT. Top level holds the Wishbone decode, TIMEOUT_CFG registers and read mux.

Test Plan:
- Reset then read STATUS ch0 with phy_ready=0 → state=0, stickies 0. Read FREQ with CLK_FREQ=200 → 16'd200, ack exactly 1 cycle.
- Write CTRL ch1=1 with RST_CYCLES=32 → qdr_reset[1] high for exactly 32 cycles, qdr_reset[0] stays low, RST_COUNT ch1=1. Raise phy_ready[1] → STATUS state=1 within 3 cycles.
- TIMEOUT_CFG=2, TO_SHIFT=8, phy_ready held low after reset request → FAIL 512 cycles after WAIT entry. Then 2 auto-retries (RST_COUNT=3), then FAIL held with STATUS[14]=1 and STATUS[12]=1.
- READY, then drop phy_ready → WAIT, STATUS[13]=1. Write CTRL=2 → stickies cleared. Write CTRL=1 → retry count cleared.
- Second reset request 10 cycles into the pulse → total pulse 42 cycles, RST_COUNT increments twice.
- Assert wb_rst_n_i low mid-pulse → qdr_reset drops immediately, asynchronously. Access to channel index 5 with NUM_CH=2 → reads 0, write has no effect.
